// File: rtl/serial_sequencer.sv
// rtl/serial_sequencer.sv - word-level TX/RX buffer sequencer feeding a 3-wire serial controller
// Streams LEN buffered words into the controller and captures each returned word.

module serial_sequencer #(
  parameter int BITS  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_wr_en,
  input  logic [AW-1:0]   in_wr_addr,
  input  logic [BITS-1:0] in_wr_data,
  input  logic [AW-1:0]   in_rd_addr,
  output logic [BITS-1:0] out_rd_data,
  input  logic            in_start,
  input  logic [AW:0]     in_len,
  output logic            out_busy,
  output logic            out_done,
  output logic            out_ser_enable,
  output logic [BITS-1:0] out_ser_parallel,
  input  logic            in_ser_ready,
  input  logic            in_ser_next_word,
  input  logic            in_ser_word_finished,
  input  logic [BITS-1:0] in_ser_parallel
);

  typedef enum logic [1:0] {IDLE, WAIT_READY, TRANSFER, DRAIN} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t          state, state_nxt;
  logic [BITS-1:0] tx_buf [DEPTH];
  logic [BITS-1:0] rx_buf [DEPTH];
  logic [AW:0]     tx_idx, tx_idx_nxt, rx_idx, len_q, len_clamped;
  logic            nw_q1, nw_q2, wf_q1, wf_q2;
  logic            nw_rise, wf_rise, last_tx, launch, capture, done_nxt;

  // Serial-side strobes may span many in_clk cycles; only their rising edge counts.
  assign nw_rise     = nw_q1 & ~nw_q2;
  assign wf_rise     = wf_q1 & ~wf_q2;
  assign len_clamped = (in_len > DEPTH_W) ? DEPTH_W : in_len;
  assign last_tx     = (tx_idx == len_q - 1'b1);
  assign launch      = (state == IDLE) && in_start && (in_len != '0);
  assign capture     = ((state == TRANSFER) || (state == DRAIN)) && wf_rise && (rx_idx < len_q);

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (launch) state_nxt = WAIT_READY;
      WAIT_READY: if (in_ser_ready) state_nxt = TRANSFER;
      TRANSFER:   if (nw_rise && last_tx) state_nxt = DRAIN;
      DRAIN:      if ((rx_idx == len_q) && in_ser_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_busy       = (state != IDLE);
    out_ser_enable = (state == TRANSFER);
    done_nxt       = ((state == IDLE) && in_start && (in_len == '0)) ||
                     ((state == DRAIN) && (rx_idx == len_q) && in_ser_ready);
    tx_idx_nxt     = tx_idx;
    if (launch)
      tx_idx_nxt = '0;
    else if ((state == TRANSFER) && nw_rise && !last_tx)
      tx_idx_nxt = tx_idx + 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      nw_q1            <= 1'b0;
      nw_q2            <= 1'b0;
      wf_q1            <= 1'b0;
      wf_q2            <= 1'b0;
      tx_idx           <= '0;
      rx_idx           <= '0;
      len_q            <= '0;
      out_done         <= 1'b0;
      out_ser_parallel <= '0;
      out_rd_data      <= '0;
    end else begin
      nw_q1       <= in_ser_next_word;
      nw_q2       <= nw_q1;
      wf_q1       <= in_ser_word_finished;
      wf_q2       <= wf_q1;
      tx_idx      <= tx_idx_nxt;
      out_done    <= done_nxt;
      out_rd_data <= rx_buf[in_rd_addr];
      // Look up with the next index so the word is ready the cycle tx_idx moves.
      out_ser_parallel <= tx_buf[tx_idx_nxt[AW-1:0]];
      if (launch) begin
        len_q  <= len_clamped;
        rx_idx <= '0;
      end else if (capture) begin
        rx_idx <= rx_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_wr_en && !out_busy) tx_buf[in_wr_addr] <= in_wr_data;
    if (capture) rx_buf[rx_idx[AW-1:0]] <= in_ser_parallel;
  end

endmodule

// File: tb/tb_serial_sequencer.sv
// tb/tb_serial_sequencer.sv - directed and randomized bench for serial_sequencer with a behavioural controller

module tb_serial_sequencer;
  localparam int BITS  = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            in_clk = 1'b0;
  logic            in_rst = 1'b0;
  logic            in_wr_en = 1'b0;
  logic [AW-1:0]   in_wr_addr = '0;
  logic [BITS-1:0] in_wr_data = '0;
  logic [AW-1:0]   in_rd_addr = '0;
  logic [BITS-1:0] out_rd_data;
  logic            in_start = 1'b0;
  logic [AW:0]     in_len = '0;
  logic            out_busy, out_done, out_ser_enable;
  logic [BITS-1:0] out_ser_parallel;
  logic            in_ser_ready, in_ser_next_word, in_ser_word_finished;
  logic [BITS-1:0] in_ser_parallel;

  serial_sequencer #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .in_rd_addr(in_rd_addr), .out_rd_data(out_rd_data),
    .in_start(in_start), .in_len(in_len),
    .out_busy(out_busy), .out_done(out_done),
    .out_ser_enable(out_ser_enable), .out_ser_parallel(out_ser_parallel),
    .in_ser_ready(in_ser_ready), .in_ser_next_word(in_ser_next_word),
    .in_ser_word_finished(in_ser_word_finished), .in_ser_parallel(in_ser_parallel)
  );

  always #5 in_clk = ~in_clk;

  int cmp = 0;
  int mis = 0;
  int done_cnt = 0;
  int en_cycles = 0;
  int words_started = 0;
  int words_done = 0;
  bit loop_back = 1'b1;
  logic sent_bits[$];
  logic [BITS-1:0] tx_m [DEPTH];
  logic [BITS-1:0] rx_m [DEPTH];
  bit rx_v [DEPTH];

  always @(negedge in_clk) begin
    if (out_done) done_cnt++;
    if (out_ser_enable) en_cycles++;
  end

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp)
    else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller: latch word, next_word strobe, shift LSB first, word_finished strobe, repeat while enabled.
  initial begin
    logic [BITS-1:0] cw, rw;
    in_ser_ready = 1'b1;
    in_ser_next_word = 1'b0;
    in_ser_word_finished = 1'b0;
    in_ser_parallel = '0;
    forever begin
      tick();
      if (out_ser_enable) begin
        in_ser_ready = 1'b0;
        do begin
          cw = out_ser_parallel;
          words_started++;
          in_ser_next_word = 1'b1;
          repeat (3) tick();
          in_ser_next_word = 1'b0;
          for (int b = 0; b < BITS; b++) begin
            sent_bits.push_back(cw[b]);
            rw[b] = loop_back ? cw[b] : 1'b1;
            repeat (4) tick();
          end
          in_ser_parallel = rw;
          in_ser_word_finished = 1'b1;
          repeat (3) tick();
          in_ser_word_finished = 1'b0;
          words_done++;
        end while (out_ser_enable);
        in_ser_ready = 1'b1;
      end
    end
  end

  task automatic write_tx(input int a, input logic [BITS-1:0] d);
    in_wr_en = 1'b1; in_wr_addr = AW'(a); in_wr_data = d;
    tick();
    in_wr_en = 1'b0;
    tx_m[a] = d;
  endtask

  task automatic read_rx(input int a);
    in_rd_addr = AW'(a);
    tick();
    if (rx_v[a]) check($sformatf("rx[%0d]", a), 32'(out_rd_data), 32'(rx_m[a]));
  endtask

  task automatic run(input int len, input bit disturb);
    int n, d0, w0, t;
    n = (len > DEPTH) ? DEPTH : len;
    d0 = done_cnt; w0 = words_done;
    in_start = 1'b1; in_len = (AW+1)'(len);
    tick();
    in_start = 1'b0;
    if (disturb) begin
      repeat (10) tick();
      in_wr_en = 1'b1; in_wr_addr = '0; in_wr_data = 8'h00;
      in_start = 1'b1; in_len = 5'd2;
      tick();
      in_wr_en = 1'b0; in_start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 4000) begin tick(); t++; end
    check($sformatf("done_seen len=%0d", len), 32'(t < 4000), 1);
    repeat (disturb ? 200 : 3) tick();
    check($sformatf("done_once len=%0d", len), 32'(done_cnt - d0), 1);
    check($sformatf("words len=%0d", len), 32'(words_done - w0), 32'(n));
    check("busy_after", 32'(out_busy), 0);
    for (int i = 0; i < n; i++) begin
      rx_m[i] = loop_back ? tx_m[i] : {BITS{1'b1}};
      rx_v[i] = 1'b1;
    end
    for (int i = 0; i < n; i++) read_rx(i);
  endtask

  initial begin
    int e0, d0, s0, t;
    logic [BITS-1:0] w;
    for (int i = 0; i < DEPTH; i++) rx_v[i] = 1'b0;

    repeat (3) tick();
    check("rst_busy", 32'(out_busy), 0);
    check("rst_done", 32'(out_done), 0);
    check("rst_enable", 32'(out_ser_enable), 0);
    check("rst_parallel", 32'(out_ser_parallel), 0);
    check("rst_rd_data", 32'(out_rd_data), 0);
    in_rst = 1'b1;
    tick();

    // Loopback of three words.
    write_tx(0, 8'hA5); write_tx(1, 8'h3C); write_tx(2, 8'hFF);
    e0 = en_cycles;
    run(3, 1'b0);
    check("enable_active_3", 32'(en_cycles > e0), 1);

    // Zero-length start.
    e0 = en_cycles; d0 = done_cnt;
    in_start = 1'b1; in_len = '0;
    tick();
    in_start = 1'b0;
    check("len0_busy", 32'(out_busy), 0);
    check("len0_done_pulse", 32'(out_done), 1);
    tick();
    check("len0_done_low", 32'(out_done), 0);
    repeat (20) tick();
    check("len0_done_count", 32'(done_cnt - d0), 1);
    check("len0_no_enable", 32'(en_cycles - e0), 0);
    check("len0_busy_late", 32'(out_busy), 0);

    // Single word with receive line tied high.
    write_tx(0, 8'h81);
    loop_back = 1'b0;
    sent_bits.delete();
    e0 = en_cycles;
    run(1, 1'b0);
    check("len1_bits", 32'(sent_bits.size()), BITS);
    for (int b = 0; b < BITS; b++) w[b] = (b < sent_bits.size()) ? sent_bits[b] : 1'bx;
    check("len1_serial_word", 32'(w), 32'h81);
    check("len1_enable_short", 32'((en_cycles - e0) >= 1 && (en_cycles - e0) <= 4), 1);
    loop_back = 1'b1;

    // Over-length request clamps to the buffer depth.
    for (int i = 0; i < DEPTH; i++) write_tx(i, BITS'($urandom));
    run(20, 1'b0);

    // Write and start while busy are both ignored.
    run(3, 1'b1);
    run(1, 1'b0);

    // Reset during the second word of a four-word transfer.
    for (int i = 0; i < 4; i++) write_tx(i, BITS'($urandom));
    s0 = words_started;
    in_start = 1'b1; in_len = 5'd4;
    tick();
    in_start = 1'b0;
    t = 0;
    while (words_started < s0 + 2 && t < 2000) begin tick(); t++; end
    check("rst_mid_reached", 32'(t < 2000), 1);
    in_rst = 1'b0;
    #1;
    check("rst_mid_enable", 32'(out_ser_enable), 0);
    check("rst_mid_busy", 32'(out_busy), 0);
    check("rst_mid_done", 32'(out_done), 0);
    check("rst_mid_parallel", 32'(out_ser_parallel), 0);
    check("rst_mid_rd_data", 32'(out_rd_data), 0);
    repeat (2) tick();
    in_rst = 1'b1;
    rx_m[0] = tx_m[0]; rx_v[0] = 1'b1;
    read_rx(0);
    t = 0;
    while (!in_ser_ready && t < 2000) begin tick(); t++; end
    repeat (4) tick();
    run(4, 1'b0);

    // Randomized transactions against the model.
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 4; j++) write_tx($urandom_range(0, DEPTH-1), BITS'($urandom));
      loop_back = 1'($urandom);
      run($urandom_range(1, 20), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_sequencer.md
Name: serial_sequencer

Overview:
- Word-level transaction sequencer that sits directly upstream of the 3-wire serial controller.
- Holds a TX buffer of up to DEPTH words, which the host loads.
- On start, drives the controller's enable and parallel-word inputs for LEN consecutive words.
- Captures every received word into an RX buffer and pulses done when the last word has finished.

Parameters:
- BITS, 8, word width; equals the controller's BITS.
- DEPTH, 16, TX/RX buffer depth in words (power of two, >= 2).
- AW, $clog2(DEPTH), buffer address width.

Ports:
- in_clk  in  1  main clock; the serial controller's clock is derived from it.
- in_rst  in  1  reset.
- in_wr_en  in  1  write in_wr_data into TX buffer at in_wr_addr.
- in_wr_addr  in  AW  TX write address.
- in_wr_data  in  BITS  TX write data.
- in_rd_addr  in  AW  RX read address.
- out_rd_data  out  BITS  RX word at in_rd_addr, registered.
- in_start  in  1  start-transaction pulse.
- in_len  in  AW+1  number of words to transfer.
- out_busy  out  1  transaction in progress.
- out_done  out  1  one-cycle pulse when the transaction completes.
- out_ser_enable  out  1  to the controller's in_enable.
- out_ser_parallel  out  BITS  to the controller's in_parallel.
- in_ser_ready  in  1  from the controller's out_ready.
- in_ser_next_word  in  1  from the controller's out_next_word.
- in_ser_word_finished  in  1  from the controller's out_word_finished.
- in_ser_parallel  in  BITS  from the controller's out_parallel.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State Idle.
  - out_busy, out_done, out_ser_enable = 0.
  - out_ser_parallel = 0, out_rd_data = 0.
  - tx_idx, rx_idx = 0, len_q = 0.
  - Buffer contents are not reset.
- Input edge detection: in_ser_next_word and in_ser_word_finished pass through two registers each.
  - nw_rise = q1 & ~q2; wf_rise likewise.
  - Exactly one in_clk event per serial-clock pulse, regardless of pulse length.
- TX buffer writes:
  - Accepted only when out_busy = 0; ignored while busy.
  - 1-cycle write.
- RX read: out_rd_data <= rx_buf[in_rd_addr] every cycle; 1-cycle latency.
- out_ser_parallel is registered and equals tx_buf[tx_idx] whenever busy.
- State machine:
  - Idle:
    - in_start=1 with in_len=0: pulse out_done next cycle, stay in Idle.
    - in_start=1 with in_len>0: len_q <= min(in_len, DEPTH), tx_idx <= 0, rx_idx <= 0, go to WaitReady.
  - WaitReady:
    - When in_ser_ready=1, assert out_ser_enable and go to Transfer.
    - out_ser_parallel already holds tx_buf[0].
  - Transfer, on nw_rise:
    - If tx_idx == len_q-1: out_ser_enable <= 0, go to Drain.
    - Otherwise: tx_idx <= tx_idx+1, so out_ser_parallel updates to the next word before the controller's next latch.
  - Transfer/Drain, on wf_rise: rx_buf[rx_idx] <= in_ser_parallel, rx_idx <= rx_idx+1.
  - Drain:
    - When rx_idx == len_q and in_ser_ready=1: pulse out_done 1 cycle, go to Idle.
- Simultaneous nw_rise and wf_rise: both actions happen in the same cycle; they are independent counters.
- out_busy = 1 in WaitReady, Transfer and Drain.
- in_start while busy: ignored.
- in_len > DEPTH: clamped to DEPTH.
- Reset mid-transaction:
  - out_ser_enable drops immediately (async).
  - The RX words already captured remain in the buffer.
- Indices are AW+1 bits wide.
  - Buffer addressing uses the low AW bits.
  - No wrap-around within a transaction.

Test Plan:
- Load TX {0xA5,0x3C,0xFF}, start len=3, with a looped-back controller (serial out -> serial in):
  - out_ser_enable high for exactly 3 words.
  - RX reads back {0xA5,0x3C,0xFF}.
  - Exactly one out_done pulse; out_busy low afterwards.
- Start len=0: out_done pulses one cycle after start; out_ser_enable never asserts; out_busy stays 0.
- Start len=1, TX[0]=0x81, with the controller's input tied to 1:
  - Serial line carries 0x81, LSB first.
  - RX[0] = 0xFF.
  - Enable drops after the first nw_rise.
- Start len=20 with DEPTH=16: exactly 16 words are transferred; rx_idx ends at 16; done pulses.
- During a busy transaction, issue a wr_en to addr 0 with 0x00 and a second start:
  - TX[0] is unchanged.
  - No second transaction occurs.
  - out_done pulses only once.
- Assert reset during word 2 of a 4-word transaction:
  - All outputs go to their reset values within the same cycle.
  - RX[0] still holds word 0.
  - A new start then completes normally.
